// File: rtl/librotator_pkg.sv
// ============================================================================
// Module : librotator_pkg
// Brief  : Shared sizing helpers for the pipelined barrel rotators.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package librotator_pkg;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int rot_parts(input int w, input int s);
        return w / s;
    endfunction

    function automatic int rot_stages(input int w, input int s);
        return $clog2(w / s);
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rotator_left_slot.sv
// ============================================================================
// Module : rotator_left_slot
// Brief  : A group of left-rotate mux stages followed by one valid/ready slot.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rotator_left_slot #(
    parameter int W      = 32,
    parameter int S      = 1,
    parameter int AW     = 5,
    parameter int FIRST  = 0,
    parameter int COUNT  = 2,
    parameter int TW     = 4,
    parameter int TAG_EN = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [AW-1:0] in_amt,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [AW-1:0] out_amt,
    output logic [TW-1:0] out_tag
);

    logic [W-1:0]  w_rot;
    logic          r_valid;
    logic [W-1:0]  r_data;
    logic [AW-1:0] r_amt;

    // Each stage's shift is strictly less than W, so both shift terms are legal.
    always_comb begin
        w_rot = in_data;
        for (int i = 0; i < COUNT; i++) begin
            if (in_amt[FIRST+i]) begin
                w_rot = (w_rot << ((2 ** (FIRST + i)) * S)) |
                        (w_rot >> (W - (2 ** (FIRST + i)) * S));
            end
        end
    end

    assign in_ready = !r_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_amt   <= '0;
        end else if (in_ready) begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_data <= w_rot;
                r_amt  <= in_amt;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_amt   = r_amt;

    if (TAG_EN != 0) begin : g_tag
        logic [TW-1:0] r_tag;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_tag <= '0;
            end else if (in_ready && in_valid) begin
                r_tag <= in_tag;
            end
        end
        assign out_tag = r_tag;
    end else begin : g_no_tag
        logic w_unused_tag;
        assign w_unused_tag = ^in_tag;
        assign out_tag      = '0;
    end

endmodule

`default_nettype wire

// File: rtl/rotator_left_pipelined.sv
// ============================================================================
// Module : rotator_left_pipelined
// Brief  : Pipelined valid/ready barrel rotator, rotates left by amt*S bits.
//          Define ROTATOR_LEFT_TAG_EN to add the in_tag/out_tag sideband.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rotator_left_pipelined
    import librotator_pkg::*;
#(
    parameter int INPUTWIDTH         = 32,
    parameter int OUTPUTWIDTH        = INPUTWIDTH,
    parameter int SHIFTBITS_PER_STEP = 1,
    parameter int REG_EVERY          = 2,
    parameter int TAGWIDTH           = 4,
    localparam int W      = max(INPUTWIDTH, OUTPUTWIDTH),
    localparam int PARTS  = rot_parts(W, SHIFTBITS_PER_STEP),
    localparam int STAGES = rot_stages(W, SHIFTBITS_PER_STEP),
    localparam int ROTW   = (STAGES > 0) ? STAGES : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUTWIDTH-1:0]  in_data,
    input  logic [ROTW-1:0]        in_rotateLeft,
`ifdef ROTATOR_LEFT_TAG_EN
    input  logic [TAGWIDTH-1:0]    in_tag,
    output logic [TAGWIDTH-1:0]    out_tag,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUTPUTWIDTH-1:0] out_data
);

    localparam int NSLOTS = (STAGES > 0) ? ceil_div(STAGES, REG_EVERY) : 1;
`ifdef ROTATOR_LEFT_TAG_EN
    localparam int TAG_EN = 1;
`else
    localparam int TAG_EN = 0;
`endif

    if ((W % SHIFTBITS_PER_STEP) != 0 || (PARTS & (PARTS - 1)) != 0) begin : g_param_err
        $error("rotator_left_pipelined: width must split into a power-of-two number of steps");
    end

    // Slot k sits between chain index k (its input) and k+1 (its output).
    logic [NSLOTS:0]     w_valid;
    logic [NSLOTS:0]     w_ready;
    logic [W-1:0]        w_data [NSLOTS+1];
    logic [ROTW-1:0]     w_amt  [NSLOTS+1];
    logic [TAGWIDTH-1:0] w_tag  [NSLOTS+1];

    assign w_valid[0]      = in_valid;
    assign in_ready        = w_ready[0];
    assign w_amt[0]        = in_rotateLeft;
    assign w_ready[NSLOTS] = out_ready;
    assign out_valid       = w_valid[NSLOTS];

    if (INPUTWIDTH < W) begin : g_zext
        assign w_data[0] = {{(W - INPUTWIDTH){1'b0}}, in_data};
    end else begin : g_no_zext
        assign w_data[0] = in_data;
    end

    // Wrap happens at W inside the slots; only the final result is truncated.
    assign out_data = w_data[NSLOTS][OUTPUTWIDTH-1:0];
    if (OUTPUTWIDTH < W) begin : g_trunc
        logic w_unused_hi;
        assign w_unused_hi = ^w_data[NSLOTS][W-1:OUTPUTWIDTH];
    end

`ifdef ROTATOR_LEFT_TAG_EN
    assign w_tag[0] = in_tag;
    assign out_tag  = w_tag[NSLOTS];
`else
    logic w_unused_tag_tail;
    assign w_tag[0]          = '0;
    assign w_unused_tag_tail = ^w_tag[NSLOTS];
`endif

    logic w_unused_amt_tail;
    assign w_unused_amt_tail = ^w_amt[NSLOTS];

    for (genvar k = 0; k < NSLOTS; k++) begin : g_slot
        localparam int FIRST = k * REG_EVERY;
        localparam int LEFT  = (STAGES > FIRST) ? (STAGES - FIRST) : 0;
        localparam int COUNT = (LEFT < REG_EVERY) ? LEFT : REG_EVERY;

        rotator_left_slot #(
            .W      (W),
            .S      (SHIFTBITS_PER_STEP),
            .AW     (ROTW),
            .FIRST  (FIRST),
            .COUNT  (COUNT),
            .TW     (TAGWIDTH),
            .TAG_EN (TAG_EN)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (w_valid[k]),
            .in_ready  (w_ready[k]),
            .in_data   (w_data[k]),
            .in_amt    (w_amt[k]),
            .in_tag    (w_tag[k]),
            .out_valid (w_valid[k+1]),
            .out_ready (w_ready[k+1]),
            .out_data  (w_data[k+1]),
            .out_amt   (w_amt[k+1]),
            .out_tag   (w_tag[k+1])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_rotator_left_pipelined.sv
// ============================================================================
// Module : tb_rotator_left_pipelined
// Brief  : Self-checking bench for rotator_left_pipelined (W=32, S=1 and S=8).
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rotator_left_pipelined;

    localparam int W = 32;
    localparam int L = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_amt;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [31:0] in_data8, out_data8;
    logic [1:0]  in_amt8;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_next;
    logic [31:0] q_data[$];
    logic [31:0] prev_data;
    logic        prev_stall = 1'b0;
    logic        rand_done  = 1'b0;

`ifdef ROTATOR_LEFT_TAG_EN
    logic [3:0]  in_tag, out_tag, in_tag8, out_tag8;
    logic [3:0]  q_tag[$];
    int          beat_cnt = 0;
`endif

    always #5 clk = ~clk;

    rotator_left_pipelined #(
        .INPUTWIDTH(32), .OUTPUTWIDTH(32), .SHIFTBITS_PER_STEP(1), .REG_EVERY(2), .TAGWIDTH(4)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_rotateLeft (in_amt),
`ifdef ROTATOR_LEFT_TAG_EN
        .in_tag        (in_tag),
        .out_tag       (out_tag),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data)
    );

    rotator_left_pipelined #(
        .INPUTWIDTH(32), .OUTPUTWIDTH(32), .SHIFTBITS_PER_STEP(8), .REG_EVERY(2), .TAGWIDTH(4)
    ) u_dut8 (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid8),
        .in_ready      (in_ready8),
        .in_data       (in_data8),
        .in_rotateLeft (in_amt8),
`ifdef ROTATOR_LEFT_TAG_EN
        .in_tag        (in_tag8),
        .out_tag       (out_tag8),
`endif
        .out_valid     (out_valid8),
        .out_ready     (out_ready8),
        .out_data      (out_data8)
    );

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: r[j] = x[(j - k*s) mod W]
    function automatic logic [31:0] rotl_ref(input logic [31:0] x, input int k, input int s);
        logic [31:0] r;
        for (int j = 0; j < W; j++) r[j] = x[(((j - k * s) % W) + W) % W];
        return r;
    endfunction

    function automatic logic [31:0] rotr_ref(input logic [31:0] x, input int k, input int s);
        logic [31:0] r;
        for (int j = 0; j < W; j++) r[j] = x[(j + k * s) % W];
        return r;
    endfunction

    // Scoreboard: every accepted beat is queued, every emitted beat must match the head.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (out_valid && q_data.size() == 0) begin
                chk_eq("spurious_out", 64'(out_valid), 64'd0);
            end else if (out_valid && out_ready) begin
                chk_eq("out_data", 64'(out_data), 64'(q_data.pop_front()));
`ifdef ROTATOR_LEFT_TAG_EN
                chk_eq("out_tag", 64'(out_tag), 64'(q_tag.pop_front()));
`endif
            end
            if (out_valid && !out_ready && prev_stall)
                chk_eq("stall_stable", 64'(out_data), 64'(prev_data));
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && in_ready) begin
                q_data.push_back(exp_next);
`ifdef ROTATOR_LEFT_TAG_EN
                q_tag.push_back(in_tag);
`endif
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_beat(input logic [31:0] d, input logic [4:0] a, input logic [31:0] e);
        int n;
        in_data  = d;
        in_amt   = a;
        exp_next = e;
`ifdef ROTATOR_LEFT_TAG_EN
        in_tag   = beat_cnt[3:0];
        beat_cnt++;
`endif
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk_eq("push_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic measure(input string tag, input logic [31:0] d, input logic [4:0] a,
                           input logic [31:0] e);
        int cnt;
        drive_beat(d, a, e);
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #1 cnt++;
        end
        chk_eq({tag, "_latency"}, 64'(cnt), 64'(L));
        chk_eq({tag, "_data"}, 64'(out_data), 64'(e));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [31:0] d, input logic [1:0] a,
                          input logic [31:0] e);
        in_data8  = d;
        in_amt8   = a;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        chk_eq({tag, "_valid"}, 64'(out_valid8), 64'd1);
        chk_eq({tag, "_data"}, 64'(out_data8), 64'(e));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_data.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1 chk_eq("drain_empty", 64'(q_data.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] x;
        logic [4:0]  a;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; in_data8 = '0; in_amt8 = '0; out_ready8 = 1'b1; exp_next = '0;
`ifdef ROTATOR_LEFT_TAG_EN
        in_tag = '0; in_tag8 = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
        chk_eq("rst_out_data", 64'(out_data), 64'd0);
        reset = 1'b0;
        #1 chk_eq("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        measure("amt4", 32'h0000_0001, 5'd4, 32'h0000_0010);
        measure("wrap1", 32'h8000_0001, 5'd1, 32'h0000_0003);
        measure("wrap31", 32'h8000_0001, 5'd31, 32'hC000_0000);
        measure("amt0", 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);

        check8("s8_amt1", 32'h1122_3344, 2'd1, 32'h2233_4411);
        check8("s8_amt3", 32'h1122_3344, 2'd3, 32'h4411_2233);
        check8("s8_amt0", 32'h1122_3344, 2'd0, 32'h1122_3344);

        // Backpressure: three slots fill, then in_ready must drop.
        out_ready = 1'b0;
        fork
            begin
                repeat (5) @(negedge clk);
                chk_eq("stall_in_ready", 64'(in_ready), 64'd0);
                chk_eq("stall_out_valid", 64'(out_valid), 64'd1);
                chk_eq("stall_head", 64'(out_data), 64'd0);
            end
            begin
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 8; i++) drive_beat(32'(i), 5'd1, 32'(2 * i));
        drain();

        // Reset with beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive_beat(32'(i + 5), 5'd2, 32'((i + 5) * 4));
        reset = 1'b1;
        #1 chk_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        q_data.delete();
`ifdef ROTATOR_LEFT_TAG_EN
        q_tag.delete();
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk_eq("midrst_quiet", 64'(out_valid), 64'd0);
        measure("postrst", 32'h0000_0001, 5'd4, 32'h0000_0010);

        // Random beats: feed a right-rotated word, the left rotation must restore it.
`ifdef ROTATOR_LEFT_TAG_EN
        beat_cnt = 0;
`endif
        fork
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 4) != 0);
                end
                out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            a = 5'($urandom_range(0, 31));
            drive_beat(rotr_ref(x, int'(a), 1), a, x);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_done = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        chk_eq("ref_model_sanity", 64'(rotl_ref(32'h8000_0001, 1, 1)), 64'h0000_0003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
